// File: rtl/fetch_pkg.sv
// Shared fetch definitions: FSM state encoding, instruction size and the queue entry layout.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_DROP = 2'd2
   } fetch_state_e;

   localparam int INSTR_BYTES  = 4;
   localparam int FETCH_DATA_W = 32;
   localparam int FETCH_ADDR_W = 32;

   // Entry layout at default widths; the top passes its own width-matched variant.
   typedef struct packed {
      logic [FETCH_DATA_W-1:0] instr;
      logic [FETCH_ADDR_W-1:0] pc_plus4;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO with single-cycle flush and a registered head entry.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter int  CNT_W   = $clog2(DEPTH) + 1,
   parameter type entry_t = fetch_entry_t
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Flush,
   input  logic             Push,
   input  entry_t           PushData,
   input  logic             Pop,
   output logic             HeadValid,
   output entry_t           HeadData,
   output logic [CNT_W-1:0] Count
);

   localparam int PTR_W = $clog2(DEPTH);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtrNext;
   logic [CNT_W-1:0] countNext;
   logic             doPop;

   assign doPop = Pop && (Count != '0);

   always_comb begin
      rdPtrNext = doPop ? rdPtr + 1'b1 : rdPtr;
      countNext = Count;
      if (Push && !doPop) countNext = Count + 1'b1;
      else if (!Push && doPop) countNext = Count - 1'b1;
   end

   // Head register tracks the post-update read slot; bypass when it is the slot being written.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         rdPtr     <= '0;
         wrPtr     <= '0;
         Count     <= '0;
         HeadValid <= 1'b0;
         HeadData  <= '0;
      end else if (Flush) begin
         rdPtr     <= '0;
         wrPtr     <= '0;
         Count     <= '0;
         HeadValid <= 1'b0;
      end else begin
         if (Push) wrPtr <= wrPtr + 1'b1;
         rdPtr     <= rdPtrNext;
         Count     <= countNext;
         HeadValid <= (countNext != '0);
         if (countNext != '0)
            HeadData <= (Push && (rdPtrNext == wrPtr)) ? PushData : mem[rdPtrNext];
      end
   end

   always_ff @(posedge Clk) begin
      if (Push && !Flush) mem[wrPtr] <= PushData;
   end

endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetcher: PC/redirect FSM feeding a small queue. Define FETCH_PERF_CNT_EN
// to add fetch and flush event counters.
module instruction_prefetch
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              BranchGateIn,
   input  logic              JrGateIn,
   input  logic              JumpIn,
   input  logic [ADDR_W-1:0] BranchAddressIn,
   input  logic [ADDR_W-1:0] JrAddressIn,
   input  logic [ADDR_W-1:0] JumpAddressIn,
   input  logic              PCWrite_DisableIn,
   output logic              IMemReqOut,
   output logic [ADDR_W-1:0] IMemAddrOut,
   input  logic              IMemGntIn,
   input  logic              IMemValidIn,
   input  logic [DATA_W-1:0] IMemDataIn,
   output logic              InstrValidOut,
   input  logic              InstrReadyIn,
   output logic [DATA_W-1:0] InstructionOut,
   output logic [ADDR_W-1:0] PCAdderOut
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       FetchCountOut,
   output logic [31:0]       FlushCountOut
`endif
);

   localparam logic [1:0]        ST_IDLE = FETCH_IDLE;
   localparam logic [1:0]        ST_WAIT = FETCH_WAIT;
   localparam logic [1:0]        ST_DROP = FETCH_DROP;
   localparam int                CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INSTR_BYTES);

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [ADDR_W-1:0] pc_plus4;
   } entry_t;

   logic [1:0]        fsmState;
   logic [1:0]        fsmStateNext;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] capAddr;
   logic [ADDR_W-1:0] redirectTarget;
   logic              redirect;
   logic              grant;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  queueCount;
   entry_t            pushEntry;
   entry_t            headEntry;

   assign redirect = BranchGateIn | JrGateIn | JumpIn;

   always_comb begin
      redirectTarget = JumpAddressIn;
      if (BranchGateIn) redirectTarget = BranchAddressIn;
      else if (JrGateIn) redirectTarget = JrAddressIn;
      redirectTarget[1:0] = 2'b00;
   end

   // Only IDLE issues, so queue room below DEPTH already covers the outstanding slot.
   assign IMemReqOut  = !Rst && (fsmState == ST_IDLE) && !PCWrite_DisableIn && !redirect &&
                        (queueCount < CNT_W'(DEPTH));
   assign IMemAddrOut = pc;
   assign grant       = IMemReqOut & IMemGntIn;
   assign push        = (fsmState == ST_WAIT) && IMemValidIn && !redirect;
   assign pop         = InstrValidOut && InstrReadyIn && !redirect;

   always_comb begin
      fsmStateNext = fsmState;
      case (fsmState)
         ST_IDLE: if (grant) fsmStateNext = redirect ? ST_DROP : ST_WAIT;
         ST_WAIT: begin
            if (IMemValidIn) fsmStateNext = ST_IDLE;
            else if (redirect) fsmStateNext = ST_DROP;
         end
         ST_DROP: if (IMemValidIn) fsmStateNext = ST_IDLE;
         default: fsmStateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         fsmState <= ST_IDLE;
         pc       <= RESET_PC;
         capAddr  <= '0;
      end else begin
         fsmState <= fsmStateNext;
         if (redirect) pc <= redirectTarget;
         else if (grant) pc <= pc + STEP;
         if (grant) capAddr <= pc;
      end
   end

   always_comb begin
      pushEntry.instr    = IMemDataIn;
      pushEntry.pc_plus4 = capAddr + STEP;
   end

   fetch_queue #(
      .DEPTH   (DEPTH),
      .CNT_W   (CNT_W),
      .entry_t (entry_t)
   ) u_queue (
      .Clk       (Clk),
      .Rst       (Rst),
      .Flush     (redirect),
      .Push      (push),
      .PushData  (pushEntry),
      .Pop       (pop),
      .HeadValid (InstrValidOut),
      .HeadData  (headEntry),
      .Count     (queueCount)
   );

   assign InstructionOut = headEntry.instr;
   assign PCAdderOut     = headEntry.pc_plus4;

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         FetchCountOut <= '0;
         FlushCountOut <= '0;
      end else begin
         if (push) FetchCountOut <= FetchCountOut + 32'd1;
         if (redirect) FlushCountOut <= FlushCountOut + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed bench for instruction_prefetch: in-order delivery, queue full, redirects,
// stall and reset during an outstanding fetch.
module tb_instruction_prefetch;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              Clk = 1'b0;
   logic              Rst = 1'b0;
   logic              BranchGateIn = 1'b0;
   logic              JrGateIn = 1'b0;
   logic              JumpIn = 1'b0;
   logic [ADDR_W-1:0] BranchAddressIn = '0;
   logic [ADDR_W-1:0] JrAddressIn = '0;
   logic [ADDR_W-1:0] JumpAddressIn = '0;
   logic              PCWrite_DisableIn = 1'b0;
   logic              IMemReqOut;
   logic [ADDR_W-1:0] IMemAddrOut;
   logic              IMemGntIn;
   logic              IMemValidIn;
   logic [DATA_W-1:0] IMemDataIn;
   logic              InstrValidOut;
   logic              InstrReadyIn = 1'b0;
   logic [DATA_W-1:0] InstructionOut;
   logic [ADDR_W-1:0] PCAdderOut;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]       FetchCountOut;
   logic [31:0]       FlushCountOut;
`endif

   // Memory model: auto mode grants immediately and answers one cycle later with A000_0000|addr.
   logic              autoGnt = 1'b0;
   logic              gntMan = 1'b0;
   logic              validMan = 1'b0;
   logic [DATA_W-1:0] manData = '0;
   logic              respValid = 1'b0;
   logic [DATA_W-1:0] respData = '0;

   int compared = 0;
   int mismatched = 0;

   assign IMemGntIn   = autoGnt ? IMemReqOut : gntMan;
   assign IMemValidIn = respValid | validMan;
   assign IMemDataIn  = validMan ? manData : respData;

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      respValid <= autoGnt && IMemReqOut && IMemGntIn;
      respData  <= 32'hA000_0000 | IMemAddrOut;
   end

   instruction_prefetch dut (
      .Clk               (Clk),
      .Rst               (Rst),
      .BranchGateIn      (BranchGateIn),
      .JrGateIn          (JrGateIn),
      .JumpIn            (JumpIn),
      .BranchAddressIn   (BranchAddressIn),
      .JrAddressIn       (JrAddressIn),
      .JumpAddressIn     (JumpAddressIn),
      .PCWrite_DisableIn (PCWrite_DisableIn),
      .IMemReqOut        (IMemReqOut),
      .IMemAddrOut       (IMemAddrOut),
      .IMemGntIn         (IMemGntIn),
      .IMemValidIn       (IMemValidIn),
      .IMemDataIn        (IMemDataIn),
      .InstrValidOut     (InstrValidOut),
      .InstrReadyIn      (InstrReadyIn),
      .InstructionOut    (InstructionOut),
      .PCAdderOut        (PCAdderOut)
`ifdef FETCH_PERF_CNT_EN
      ,
      .FetchCountOut     (FetchCountOut),
      .FlushCountOut     (FlushCountOut)
`endif
   );

   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic waitValid(input string tag);
      int n = 0;
      while (InstrValidOut !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      if (InstrValidOut !== 1'b1) begin
         compared++;
         mismatched++;
         $error("FAIL %s: no valid head within 40 cycles, observed %b expected 1", tag, InstrValidOut);
      end
   endtask

   task automatic expectHead(input string tag, input logic [DATA_W-1:0] instr,
                             input logic [ADDR_W-1:0] pcPlus4);
      waitValid(tag);
      check({tag, "_instr"}, 64'(InstructionOut), 64'(instr));
      check({tag, "_pc4"}, 64'(PCAdderOut), 64'(pcPlus4));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      #1 Rst = 1'b1;
      #3;
      check("rst_req", 64'(IMemReqOut), 64'd0);
      check("rst_valid", 64'(InstrValidOut), 64'd0);
      check("rst_instr", 64'(InstructionOut), 64'd0);
      check("rst_pc4", 64'(PCAdderOut), 64'd0);
      tick();
      tick();
      Rst = 1'b0;
      autoGnt = 1'b1;
      InstrReadyIn = 1'b1;
      #1;
      check("first_req", 64'(IMemReqOut), 64'd1);
      check("first_addr", 64'(IMemAddrOut), 64'h0);

      // In-order delivery with an immediate-grant, 1-cycle memory
      expectHead("seq0", 32'hA000_0000, 32'h4);
      expectHead("seq1", 32'hA000_0004, 32'h8);
      expectHead("seq2", 32'hA000_0008, 32'hC);

      // Consumer stalled: queue fills to DEPTH and requests stop
      InstrReadyIn = 1'b0;
      repeat (16) tick();
      #1;
      check("full_req", 64'(IMemReqOut), 64'd0);
      check("full_valid", 64'(InstrValidOut), 64'd1);
      check("full_head", 64'(PCAdderOut), 64'h10);
      repeat (3) tick();
      #1;
      check("full_req_hold", 64'(IMemReqOut), 64'd0);
      InstrReadyIn = 1'b1;
      expectHead("drain0", 32'hA000_000C, 32'h10);
      expectHead("drain1", 32'hA000_0010, 32'h14);
      expectHead("drain2", 32'hA000_0014, 32'h18);
      expectHead("drain3", 32'hA000_0018, 32'h1C);
      expectHead("drain4", 32'hA000_001C, 32'h20);

      // Branch during WAIT: in-flight response dropped
      autoGnt = 1'b0;
      repeat (4) tick();
      #1;
      check("br_idle_req", 64'(IMemReqOut), 64'd1);
      gntMan = 1'b1;
      tick();
      gntMan = 1'b0;
      #1;
      check("br_wait_req", 64'(IMemReqOut), 64'd0);
      BranchGateIn = 1'b1;
      BranchAddressIn = 32'h100;
      tick();
      BranchGateIn = 1'b0;
      #1;
      check("br_drop_req", 64'(IMemReqOut), 64'd0);
      check("br_drop_valid", 64'(InstrValidOut), 64'd0);
      validMan = 1'b1;
      manData = 32'hDEAD_BEEF;
      tick();
      validMan = 1'b0;
      #1;
      check("br_discard_valid", 64'(InstrValidOut), 64'd0);
      check("br_next_req", 64'(IMemReqOut), 64'd1);
      check("br_next_addr", 64'(IMemAddrOut), 64'h100);
      autoGnt = 1'b1;
      expectHead("br_fetch", 32'hA000_0100, 32'h104);

      // All three redirects at once on a full queue: branch wins, queue flushed
      InstrReadyIn = 1'b0;
      repeat (16) tick();
      #1;
      check("prio_full_valid", 64'(InstrValidOut), 64'd1);
      BranchGateIn = 1'b1;
      BranchAddressIn = 32'h102;
      JrGateIn = 1'b1;
      JrAddressIn = 32'h200;
      JumpIn = 1'b1;
      JumpAddressIn = 32'h300;
      #1;
      check("prio_req_withdrawn", 64'(IMemReqOut), 64'd0);
      tick();
      BranchGateIn = 1'b0;
      JrGateIn = 1'b0;
      JumpIn = 1'b0;
      #1;
      check("prio_flush_valid", 64'(InstrValidOut), 64'd0);
      check("prio_addr", 64'(IMemAddrOut), 64'h100);
      check("prio_req", 64'(IMemReqOut), 64'd1);
      InstrReadyIn = 1'b1;
      expectHead("prio_fetch", 32'hA000_0100, 32'h104);

      // Stall for 5 cycles: no requests, queue drains, fetch resumes at held PC
      InstrReadyIn = 1'b0;
      JumpIn = 1'b1;
      JumpAddressIn = 32'h400;
      tick();
      JumpIn = 1'b0;
      waitValid("stall_fill");
      PCWrite_DisableIn = 1'b1;
      #1;
      check("stall_req_off", 64'(IMemReqOut), 64'd0);
      check("stall_head", 64'(PCAdderOut), 64'h404);
      InstrReadyIn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         #1;
         check("stall_req_hold", 64'(IMemReqOut), 64'd0);
      end
      check("stall_drained", 64'(InstrValidOut), 64'd0);
      PCWrite_DisableIn = 1'b0;
      #1;
      check("stall_resume_req", 64'(IMemReqOut), 64'd1);
      check("stall_resume_addr", 64'(IMemAddrOut), 64'h404);
      expectHead("stall_fetch", 32'hA000_0404, 32'h408);

      // Reset mid-WAIT; late response must be ignored
      autoGnt = 1'b0;
      repeat (4) tick();
      #1;
      check("rw_idle_req", 64'(IMemReqOut), 64'd1);
      gntMan = 1'b1;
      tick();
      gntMan = 1'b0;
      Rst = 1'b1;
      #1;
      check("rw_rst_req", 64'(IMemReqOut), 64'd0);
      check("rw_rst_valid", 64'(InstrValidOut), 64'd0);
      check("rw_rst_instr", 64'(InstructionOut), 64'd0);
      check("rw_rst_pc4", 64'(PCAdderOut), 64'd0);
      tick();
      Rst = 1'b0;
      validMan = 1'b1;
      manData = 32'h0BAD_0BAD;
      #1;
      check("rw_addr", 64'(IMemAddrOut), 64'h0);
      tick();
      validMan = 1'b0;
      #1;
      check("rw_ignored_valid", 64'(InstrValidOut), 64'd0);
      check("rw_req", 64'(IMemReqOut), 64'd1);
      autoGnt = 1'b1;
      expectHead("rw_fetch", 32'hA000_0000, 32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/instruction_prefetch.md
INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

Interface
REQ-001 Parameter ADDR_W, default 32, PC and address width in bits.
REQ-002 Parameter DATA_W, default 32, instruction width in bits.
REQ-003 Parameter DEPTH, default 4, prefetch queue entries; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset; ports listed in REQ-006 to REQ-020.
REQ-006 Clk  in  1  rising-edge clock.
REQ-007 Rst  in  1  asynchronous active-high reset.
REQ-008 BranchGateIn  in  1  taken-branch redirect request.
REQ-009 JrGateIn  in  1  jump-register redirect request.
REQ-010 JumpIn  in  1  jump redirect request.
REQ-011 BranchAddressIn, JrAddressIn, JumpAddressIn  in  ADDR_W each  redirect targets.
REQ-012 PCWrite_DisableIn  in  1  stall: no new memory request issued while high.
REQ-013 IMemReqOut  out  1  fetch request valid.
REQ-014 IMemAddrOut  out  ADDR_W  fetch address.
REQ-015 IMemGntIn  in  1  memory accepted request this cycle.
REQ-016 IMemValidIn  in  1  response data valid.
REQ-017 IMemDataIn  in  DATA_W  response instruction.
REQ-018 InstrValidOut  out  1  queue head valid.
REQ-019 InstrReadyIn  in  1  consumer accepts head.
REQ-020 InstructionOut  out  DATA_W and PCAdderOut  out  ADDR_W  head instruction and its PC+4.

Function
REQ-021 FSM states: IDLE (no request outstanding), WAIT (accepted, awaiting response), DROP (accepted, response to be discarded).
REQ-022 IDLE: IMemReqOut = 1 when PCWrite_DisableIn = 0, no redirect this cycle, and queue occupancy < DEPTH; IMemAddrOut = PC.
REQ-023 IMemReqOut and IMemAddrOut SHALL stay stable until IMemGntIn, except where a redirect or stall withdraws the request.
REQ-024 On grant: PC <= PC+4 (modulo 2^ADDR_W); FSM -> WAIT; the fetched address is captured.
REQ-025 WAIT with IMemValidIn: push {IMemDataIn, captured address+4}; FSM -> IDLE; next request no earlier than the following cycle.
REQ-026 IMemValidIn in IDLE SHALL be ignored.
REQ-027 Redirect priority: BranchGateIn > JrGateIn > JumpIn; the selected target, low two bits forced to 0, loads PC next edge.
REQ-028 Redirect SHALL flush the queue the same edge; InstrValidOut = 0 the following cycle.
REQ-029 Redirect in WAIT, or coincident with a grant -> DROP.
REQ-030 Redirect in DROP updates PC and stays in DROP.
REQ-031 DROP with IMemValidIn: discard data -> IDLE.
REQ-032 Pop when InstrValidOut & InstrReadyIn; pop coincident with redirect is void (flush wins); push and pop in the same cycle keep occupancy unchanged.
REQ-033 Queue pointers wrap modulo DEPTH; occupancy plus outstanding request never exceeds DEPTH, so overflow is impossible.
REQ-034 Head outputs SHALL be registered.

Reset
REQ-035 On Rst: PC = RESET_PC; FSM = IDLE; queue empty; IMemReqOut, InstrValidOut = 0; InstructionOut, PCAdderOut = 0.
REQ-036 Reset mid-WAIT abandons the transaction; a late response arrives in IDLE and is ignored per REQ-026.

Configuration
REQ-037 With FETCH_PERF_CNT_EN defined: outputs FetchCountOut (32, +1 per accepted push) and FlushCountOut (32, +1 per redirect) exist, wrapping at 2^32 and cleared by Rst.
REQ-038 Without FETCH_PERF_CNT_EN: those ports and counters are absent; all other behaviour is identical.

Structure
REQ-039 Shared package fetch_pkg: FSM state enum, INSTR_BYTES = 4 constant, and the queue entry struct {instr, pc_plus4}.
REQ-040 Sub-module fetch_queue: synchronous FIFO with a single-cycle flush input; FSM and PC logic stay in the top module.

Verification
REQ-041 Reset, memory grants immediately and responds with 1-cycle latency, ready held at 1 -> instructions delivered in order with PCAdderOut 0x4, 0x8, 0xC.
REQ-042 InstrReadyIn = 0, DEPTH = 4 -> exactly 4 entries queued, then IMemReqOut = 0 until a pop.
REQ-043 BranchGateIn = 1 with target 0x100 during WAIT -> in-flight response discarded, next IMemAddrOut = 0x100, queue empty.
REQ-044 BranchGateIn, JrGateIn and JumpIn all 1 with targets 0x100, 0x200 and 0x300 -> PC = 0x100.
REQ-045 PCWrite_DisableIn = 1 for 5 cycles -> no new request; queue drains normally; fetch resumes at the unchanged PC.
REQ-046 Rst asserted during WAIT, response arrives afterwards -> ignored; first fetch at RESET_PC.
